imem_arbiter: RTL and testbench

// Sequences and shares the single-port synchronous instruction memory between two requesters:
// the IF-stage fetch port (read) and the program loader (write, fed by the boot/debug link).

---
 rtl/imem_arbiter.sv | 123 ++++++++++++
 tb/tb_imem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Shares the single-port IMEM between the IF fetch port and the program loader,
// and holds the core in stall while an image is (re)loaded.
//
// state     | meaning
// ST_BOOT   | loader owns IMEM after reset, core held
// ST_RUN    | fetch owns IMEM, core running
// ST_DRAIN  | one idle cycle so the last RUN read can return
// ST_RELOAD | loader owns IMEM again, core held
module imem_arbiter #(
    parameter int IMEM_ADDR_WIDTH = 32,
    parameter int IMEM_DATA_DEPTH = 2048,
    parameter bit BOOT_LOAD       = 1'b1,
    localparam int MEM_AW         = $clog2(IMEM_DATA_DEPTH)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fetch_req,
    input  logic [IMEM_ADDR_WIDTH-1:0] fetch_addr,
    output logic                       fetch_gnt,
    output logic                       fetch_rvalid,
    output logic [31:0]                fetch_rdata,
    output logic                       fetch_err,
    input  logic                       load_req,
    input  logic [IMEM_ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]                load_wdata,
    input  logic                       load_done,
    output logic                       load_gnt,
    output logic                       load_err,
    output logic [MEM_AW:0]            load_count,
    output logic                       core_hold,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [MEM_AW-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata
);

    localparam logic [MEM_AW:0] COUNT_MAX = (MEM_AW+1)'(IMEM_DATA_DEPTH);
    localparam logic [IMEM_ADDR_WIDTH:0] ADDR_LIMIT =
        (IMEM_ADDR_WIDTH+1)'(64'(IMEM_DATA_DEPTH) * 64'd4);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RELOAD = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   fetch_bad;
    logic   load_bad;
    logic   rd_valid;
    logic   rd_err;

    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= ADDR_LIMIT);
    assign load_bad  = (load_addr[1:0]  != 2'b00) || ({1'b0, load_addr}  >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if (BOOT_LOAD) state <= ST_BOOT;
            else           state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT, ST_RELOAD: if (load_done) state_nxt = ST_RUN;
            ST_RUN:             if (load_req)  state_nxt = ST_DRAIN;
            ST_DRAIN:           state_nxt = ST_RELOAD;
            default:            state_nxt = state;
        endcase
    end

    // A loader request in RUN blocks fetch immediately so DRAIN only ever
    // has at most one read to let through.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        case (state)
            ST_BOOT, ST_RELOAD: load_gnt  = load_req;
            ST_RUN:             fetch_gnt = fetch_req && !load_req;
            default: begin
                fetch_gnt = 1'b0;
                load_gnt  = 1'b0;
            end
        endcase
    end

    assign mem_en    = (fetch_gnt && !fetch_bad) || (load_gnt && !load_bad);
    assign mem_we    = load_gnt && !load_bad;
    assign mem_addr  = load_gnt ? load_addr[MEM_AW+1:2] : fetch_addr[MEM_AW+1:2];
    assign mem_wdata = load_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            load_err   <= 1'b0;
            load_count <= '0;
            core_hold  <= BOOT_LOAD;
        end else begin
            rd_valid  <= fetch_gnt;
            rd_err    <= fetch_gnt && fetch_bad;
            load_err  <= load_gnt && load_bad;
            core_hold <= (state_nxt != ST_RUN);
            if (state == ST_DRAIN)
                load_count <= '0;
            else if (mem_we && (load_count != COUNT_MAX))
                load_count <= load_count + 1'b1;
        end
    end

    // IMEM returns data the cycle after the access, so rdata is steered combinationally.
    assign fetch_rvalid = rd_valid;
    assign fetch_err    = rd_err;
    assign fetch_rdata  = !rd_valid ? 32'h0 : (rd_err ? NOP : mem_rdata);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a transaction-level
// model of arbitration, IMEM contents and load accounting.
module tb_imem_arbiter;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        load_req;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic        load_done;
    logic        load_gnt;
    logic        load_err;
    logic [AW:0] load_count;
    logic        core_hold;
    logic        mem_en;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(
        .IMEM_ADDR_WIDTH(32),
        .IMEM_DATA_DEPTH(DEPTH),
        .BOOT_LOAD(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_done(load_done), .load_gnt(load_gnt), .load_err(load_err),
        .load_count(load_count), .core_hold(core_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    // IMEM macro: synchronous single port, pre-filled with a known pattern
    logic [31:0] macro [DEPTH];
    bit          macro_init = 1'b0;
    always @(posedge clk) begin
        if (!macro_init) begin
            for (int i = 0; i < DEPTH; i++) macro[i] <= seed_word(i);
            macro_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) macro[mem_addr] <= mem_wdata;
            else        mem_rdata <= macro[mem_addr];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 boot, 1 run, 2 drain, 3 reload
    logic [31:0] ref_mem [DEPTH];
    int          m_st;
    bit          e_rv, e_ferr, e_lerr, e_hold;
    logic [31:0] e_rdata;
    int          e_cnt;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (longint'(a) >= longint'(4 * DEPTH));
    endfunction

    task automatic model_reset();
        m_st    = 0;
        e_rv    = 1'b0;
        e_ferr  = 1'b0;
        e_lerr  = 1'b0;
        e_rdata = 32'h0;
        e_cnt   = 0;
        e_hold  = 1'b1;
    endtask

    task automatic step(input logic rn, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic [31:0] la, input logic [31:0] lw,
                        input logic ld);
        bit fb, lb, fg, lg;
        @(negedge clk);
        resetn = rn; fetch_req = fr; fetch_addr = fa;
        load_req = lr; load_addr = la; load_wdata = lw; load_done = ld;
        #1;
        fb = addr_bad(fa);
        lb = addr_bad(la);
        lg = (m_st == 0 || m_st == 3) && lr;
        fg = (m_st == 1) && !lr && fr;
        chk_val("fetch_gnt", 32'(fetch_gnt), 32'(fg));
        chk_val("load_gnt",  32'(load_gnt),  32'(lg));
        chk_val("mem_en",    32'(mem_en),    32'((fg && !fb) || (lg && !lb)));
        chk_val("mem_we",    32'(mem_we),    32'(lg && !lb));
        if (fg && !fb) chk_val("mem_addr_fetch", 32'(mem_addr), fa / 4);
        if (lg && !lb) begin
            chk_val("mem_addr_load", 32'(mem_addr), la / 4);
            chk_val("mem_wdata", mem_wdata, lw);
        end
        chk_val("fetch_rvalid", 32'(fetch_rvalid), 32'(e_rv));
        chk_val("fetch_err",    32'(fetch_err),    32'(e_ferr));
        chk_val("fetch_rdata",  fetch_rdata,       e_rdata);
        chk_val("load_err",     32'(load_err),     32'(e_lerr));
        chk_val("load_count",   32'(load_count),   32'(e_cnt));
        chk_val("core_hold",    32'(core_hold),    32'(e_hold));
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            e_rv    = fg;
            e_ferr  = fg && fb;
            e_rdata = fg ? (fb ? NOP : ref_mem[fa / 4]) : 32'h0;
            e_lerr  = lg && lb;
            if (lg && !lb) begin
                ref_mem[la / 4] = lw;
                if (e_cnt < DEPTH) e_cnt++;
            end
            case (m_st)
                0, 3: if (ld) m_st = 1;
                1:    if (lr) m_st = 2;
                default: begin
                    m_st  = 3;
                    e_cnt = 0;
                end
            endcase
            e_hold = (m_st != 1);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic ld);
        step(1'b1, 1'b0, 32'h0, 1'b1, a, d, ld);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        step(1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 10);
        if (r < 7)       return 32'(4 * $urandom_range(0, 63));
        else if (r == 7) return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        else if (r == 8) return 32'(32'h2000 + 4 * $urandom_range(0, 1000));
        else if (r == 9) return $urandom;
        else             return 32'h0000_1FFC;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        resetn = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
        load_req = 1'b0; load_addr = 32'h0; load_wdata = 32'h0; load_done = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();

        // boot image, then release the core
        do_load(32'h0, 32'hA000_0000, 1'b0);
        do_load(32'h4, 32'hA000_0004, 1'b0);
        do_load(32'h8, 32'hA000_0008, 1'b0);
        do_load(32'hC, 32'hA000_000C, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        do_fetch(32'h0);
        do_fetch(32'h4);
        do_fetch(32'h8);
        idle();

        // loader interrupts a running fetch stream
        do_fetch(32'hC);
        step(1'b1, 1'b1, 32'h4, 1'b1, 32'h10, 32'hB000_0010, 1'b0);
        step(1'b1, 1'b1, 32'h4, 1'b1, 32'h10, 32'hB000_0010, 1'b1);
        step(1'b1, 1'b1, 32'h4, 1'b1, 32'h10, 32'hB000_0010, 1'b0);
        do_load(32'h3, 32'hDEAD_BEEF, 1'b0);
        idle();
        do_load(32'h14, 32'hC000_0014, 1'b1);
        do_fetch(32'h14);
        do_fetch(32'h10);
        do_fetch(32'h2);
        do_fetch(32'h2000);
        do_fetch(32'h1FFC);
        idle();

        // reset lands while a read is in flight
        do_fetch(32'h0);
        step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();

        // load_count saturation
        for (int i = 0; i < DEPTH + 3; i++)
            do_load(32'(4 * (i % DEPTH)), 32'(i) ^ 32'h5A5A_0000, 1'b0);
        idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) != 0), rand_addr(),
                 ($urandom_range(0, 3) == 0), rand_addr(), $urandom,
                 ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
